// File: rtl/mem_req_framer_pkg.sv
// Shared constants, state encoding and byte-formatting helpers for the
// memory-gateway request framer.
package mem_req_framer_pkg;

  localparam logic [7:0] CMD_RD  = 8'h10;
  localparam logic [7:0] CMD_WR  = 8'h00;
  localparam int         HDR_LEN = 8;
  localparam int         REC_LEN = 8;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } state_t;

  // 57-bit buffered command: rd flag, 24-bit address, 32-bit write data.
  typedef struct packed {
    logic        rd;
    logic [23:0] addr;
    logic [31:0] data;
  } rec_t;

  function automatic logic [7:0] hdr_byte(input logic [31:0] s, input logic [2:0] b);
    logic [7:0] v;
    v = '0;
    case (b)
      3'd4:    v = s[31:24];
      3'd5:    v = s[23:16];
      3'd6:    v = s[15:8];
      3'd7:    v = s[7:0];
      default: v = '0;
    endcase
    return v;
  endfunction

  // Read records carry zero in the data field, whatever was buffered.
  function automatic logic [7:0] rec_byte(input rec_t r, input logic [2:0] f);
    logic [7:0] v;
    v = '0;
    case (f)
      3'd0:    v = r.rd ? CMD_RD : CMD_WR;
      3'd1:    v = r.addr[23:16];
      3'd2:    v = r.addr[15:8];
      3'd3:    v = r.addr[7:0];
      3'd4:    v = r.rd ? 8'h00 : r.data[31:24];
      3'd5:    v = r.rd ? 8'h00 : r.data[23:16];
      3'd6:    v = r.rd ? 8'h00 : r.data[15:8];
      default: v = r.rd ? 8'h00 : r.data[7:0];
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mem_req_buffer.sv
// Command buffer: one synchronous write port, one asynchronous read port
// indexed by record number.
module mem_req_buffer
  import mem_req_framer_pkg::*;
#(
  parameter int max_ops = 8,
  parameter int aw      = 3
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [aw-1:0] i_wr_idx,
  input  rec_t          i_wr_rec,
  input  logic [aw-1:0] i_rd_idx,
  output rec_t          o_rd_rec
);

  rec_t r_mem [max_ops];

  // NOTE: the storage has no reset; the framer's count decides which
  // entries are valid, so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_rec;
  end

  assign o_rd_rec = r_mem[i_rd_idx];

endmodule

// File: rtl/mem_req_framer.sv
// Collects local-bus commands and streams them as one gateway request
// packet through an aggregate client transmit port.
module mem_req_framer
  import mem_req_framer_pkg::*;
#(
  parameter int jumbo_dw = 14,
  parameter int max_ops  = 8,
  parameter int aw       = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rd,
  input  logic [23:0]         cmd_addr,
  input  logic [31:0]         cmd_data,
  input  logic                flush,
  output logic                tx_req,
  output logic [jumbo_dw-1:0] tx_len,
  input  logic                tx_ack,
  input  logic                tx_strobe,
  output logic [7:0]          tx_data,
  output logic                busy,
  output logic [31:0]         seq
);

  localparam logic [jumbo_dw-1:0] L_HDR = jumbo_dw'(HDR_LEN);
  localparam logic [jumbo_dw-1:0] L_REC = jumbo_dw'(REC_LEN);
  localparam logic [aw:0]         L_MAX = (aw+1)'(max_ops);

  state_t              r_state;
  logic [aw:0]         r_count;
  logic [jumbo_dw-1:0] r_idx;
  logic [31:0]         r_seq;
  logic [jumbo_dw-1:0] r_tx_len;
  logic [7:0]          r_tx_data;
  logic                r_cmd_ready;
  logic                r_tx_req;
  logic                r_busy;

  logic                w_accept;
  logic [aw:0]         w_count_post;
  logic                w_send_now;
  logic [jumbo_dw-1:0] w_byte_idx;
  logic [jumbo_dw-1:0] w_rel;
  logic [aw-1:0]       w_rec_idx;
  rec_t                w_wr_rec;
  rec_t                w_rd_rec;
  logic [7:0]          w_next_byte;
  logic                w_last;

  assign w_accept     = cmd_valid & r_cmd_ready;
  assign w_count_post = r_count + (aw+1)'(w_accept);
  assign w_send_now   = (w_count_post == L_MAX) || (flush && (w_count_post != '0));

  // Byte that the next load places on tx_data: 0 on grant, idx+1 on a strobe.
  assign w_byte_idx  = (r_state == SEND) ? r_idx + 1'b1 : '0;
  assign w_rel       = w_byte_idx - L_HDR;
  assign w_rec_idx   = aw'(w_rel >> 3);
  assign w_next_byte = (w_byte_idx < L_HDR) ? hdr_byte(r_seq, 3'(w_byte_idx))
                                            : rec_byte(w_rd_rec, 3'(w_rel));
  assign w_last      = (r_idx == r_tx_len - 1'b1);

  assign w_wr_rec = '{rd: cmd_rd, addr: cmd_addr, data: cmd_data};

  mem_req_buffer #(
    .max_ops (max_ops),
    .aw      (aw)
  ) u_buffer (
    .clk      (clk),
    .i_wr_en  (w_accept),
    .i_wr_idx (r_count[aw-1:0]),
    .i_wr_rec (w_wr_rec),
    .i_rd_idx (w_rec_idx),
    .o_rd_rec (w_rd_rec)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_count     <= '0;
      r_idx       <= '0;
      r_seq       <= '0;
      r_tx_len    <= '0;
      r_tx_data   <= '0;
      r_cmd_ready <= 1'b1;
      r_tx_req    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) r_count <= w_count_post;
          if (w_send_now) begin
            r_state     <= REQ;
            r_tx_len    <= L_HDR + L_REC * jumbo_dw'(w_count_post);
            r_cmd_ready <= 1'b0;
            r_tx_req    <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        REQ: begin
          if (tx_ack) begin
            r_state   <= SEND;
            r_idx     <= '0;
            r_tx_data <= w_next_byte;
            r_tx_req  <= 1'b0;
          end
        end
        SEND: begin
          if (tx_strobe) begin
            if (w_last) begin
              r_state     <= FILL;
              r_count     <= '0;
              r_seq       <= r_seq + 32'd1;
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_tx_data <= w_next_byte;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign tx_req    = r_tx_req;
  assign tx_len    = r_tx_len;
  assign tx_data   = r_tx_data;
  assign busy      = r_busy;
  assign seq       = r_seq;

endmodule

// File: tb/tb_mem_req_framer.sv
// Scoreboard bench for mem_req_framer: stimulus pushes expected packets,
// a negedge monitor compares every strobed byte.
`timescale 1ns/1ps
module tb_mem_req_framer;

  localparam int JDW  = 14;
  localparam int MAXN = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic           cmd_rd = 1'b0;
  logic [23:0]    cmd_addr = '0;
  logic [31:0]    cmd_data = '0;
  logic           flush = 1'b0;
  logic           tx_req;
  logic [JDW-1:0] tx_len;
  logic           tx_ack = 1'b0;
  logic           tx_strobe = 1'b0;
  logic [7:0]     tx_data;
  logic           busy;
  logic [31:0]    seq;

  always #5 clk = ~clk;

  mem_req_framer #(.jumbo_dw(JDW), .max_ops(MAXN), .aw(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rd    (cmd_rd),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .flush     (flush),
    .tx_req    (tx_req),
    .tx_len    (tx_len),
    .tx_ack    (tx_ack),
    .tx_strobe (tx_strobe),
    .tx_data   (tx_data),
    .busy      (busy),
    .seq       (seq)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_bytes[$];
  int          exp_len[$];
  bit          m_rd[$];
  logic [23:0] m_addr[$];
  logic [31:0] m_data[$];
  logic [31:0] m_seq = '0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the packet the DUT must emit for the currently buffered commands.
  task automatic push_packet();
    int n;
    n = m_rd.size();
    exp_len.push_back(8 + 8 * n);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(8'h00);
    exp_bytes.push_back(m_seq[31:24]);
    exp_bytes.push_back(m_seq[23:16]);
    exp_bytes.push_back(m_seq[15:8]);
    exp_bytes.push_back(m_seq[7:0]);
    for (int i = 0; i < n; i++) begin
      exp_bytes.push_back(m_rd[i] ? 8'h10 : 8'h00);
      exp_bytes.push_back(m_addr[i][23:16]);
      exp_bytes.push_back(m_addr[i][15:8]);
      exp_bytes.push_back(m_addr[i][7:0]);
      exp_bytes.push_back(m_rd[i] ? 8'h00 : m_data[i][31:24]);
      exp_bytes.push_back(m_rd[i] ? 8'h00 : m_data[i][23:16]);
      exp_bytes.push_back(m_rd[i] ? 8'h00 : m_data[i][15:8]);
      exp_bytes.push_back(m_rd[i] ? 8'h00 : m_data[i][7:0]);
    end
    m_rd.delete();
    m_addr.delete();
    m_data.delete();
    m_seq++;
  endtask

  always @(negedge clk) begin
    if (mon_en && tx_strobe) begin
      if (exp_bytes.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tx_data: got %h with no byte expected at %0t", tx_data, $time);
      end else begin
        check("tx_data", {24'h0, tx_data}, {24'h0, exp_bytes.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit rd, input logic [23:0] a, input logic [31:0] d, input bit fl);
    int n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    check("cmd_ready_before_issue", {31'h0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = a; cmd_data = d; flush = fl;
    m_rd.push_back(rd); m_addr.push_back(a); m_data.push_back(d);
    tick();
    cmd_valid = 1'b0; flush = 1'b0;
    if (fl || m_rd.size() == MAXN) push_packet();
  endtask

  task automatic wait_req(output int len);
    int n = 0;
    while (!tx_req && n < 200) begin tick(); n++; end
    check("tx_req_up", {31'h0, tx_req}, 32'd1);
    len = (exp_len.size() != 0) ? exp_len.pop_front() : 0;
    check("tx_len", {18'h0, tx_len}, len);
  endtask

  // Aggregate model: grant after ack_delay cycles, then strobe the packet out.
  task automatic serve(input int ack_delay, input bit gap, input int stray_pre,
                       input int stray_post, input bit ready_low);
    int len;
    wait_req(len);
    for (int k = 0; k < ack_delay; k++) begin
      tx_strobe = (k < stray_pre);
      tick();
    end
    tx_strobe = 1'b0;
    check("busy_in_req", {31'h0, busy}, 32'd1);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    check("tx_req_fall", {31'h0, tx_req}, 32'd0);
    mon_en = 1'b1;
    for (int k = 0; k < len; k++) begin
      if (ready_low && k == len - 1) check("cmd_ready_low", {31'h0, cmd_ready}, 32'd0);
      tx_strobe = 1'b1;
      tick();
      tx_strobe = 1'b0;
      if (k == len - 1) check("cmd_ready_back", {31'h0, cmd_ready}, 32'd1);
      if (gap) tick();
    end
    mon_en = 1'b0;
    check("busy_clear", {31'h0, busy}, 32'd0);
    check("seq_after", seq, m_seq);
    if (stray_post > 0) begin
      tx_strobe = 1'b1;
      repeat (stray_post) tick();
      tx_strobe = 1'b0;
      check("seq_after_stray", seq, m_seq);
      check("tx_req_after_stray", {31'h0, tx_req}, 32'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 32'd1);
    check({tag, "_tx_req"}, {31'h0, tx_req}, 32'd0);
    check({tag, "_tx_len"}, {18'h0, tx_len}, 32'd0);
    check({tag, "_tx_data"}, {24'h0, tx_data}, 32'd0);
    check({tag, "_busy"}, {31'h0, busy}, 32'd0);
    check({tag, "_seq"}, seq, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    repeat (2) tick();
    rst_n = 1'b1;
    check_reset_values("reset");

    // Single write then flush; grant after 3 cycles.
    issue(1'b0, 24'h00007a, 32'h1, 1'b0);
    check("no_req_before_flush", {31'h0, tx_req}, 32'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    push_packet();
    check("req_after_flush", {31'h0, tx_req}, 32'd1);
    serve(3, 1'b0, 0, 0, 1'b0);
    check("seq_one", seq, 32'd1);

    // Buffer fills at 8 reads without a flush.
    for (int i = 0; i < MAXN; i++) begin
      issue(1'b1, 24'(i), 32'hdead0000 + 32'(i), 1'b0);
      if (i == MAXN - 2) check("no_req_at_7", {31'h0, tx_req}, 32'd0);
    end
    check("req_after_8th", {31'h0, tx_req}, 32'd1);
    check("cmd_ready_full", {31'h0, cmd_ready}, 32'd0);
    serve(1, 1'b0, 0, 0, 1'b1);

    // Flush on empty buffer is ignored; flush with first accept sends N=1.
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (2) tick();
    check("empty_flush_no_req", {31'h0, tx_req}, 32'd0);
    check("empty_flush_not_busy", {31'h0, busy}, 32'd0);
    issue(1'b0, 24'habcdef, 32'h12345678, 1'b1);
    check("coincident_flush_req", {31'h0, tx_req}, 32'd1);
    check("coincident_flush_len", {18'h0, tx_len}, 32'd16);
    serve(0, 1'b0, 0, 0, 1'b0);

    // Gapped strobes with stray strobes before the grant and after the packet.
    issue(1'b0, 24'h102030, 32'ha5a5c3c3, 1'b0);
    issue(1'b1, 24'h405060, 32'hffffffff, 1'b1);
    serve(4, 1'b1, 3, 3, 1'b0);

    // Reset while byte 5 of a 24-byte packet is on the bus.
    issue(1'b0, 24'h000100, 32'h11111111, 1'b0);
    issue(1'b1, 24'h000200, 32'h0, 1'b1);
    wait_req(len);
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tx_strobe = 1'b1; tick(); tx_strobe = 1'b0;
    end
    mon_en = 1'b0;
    rst_n = 1'b0; tick();
    check_reset_values("midsend_reset");
    rst_n = 1'b1;
    exp_bytes.delete();
    m_seq = '0;
    issue(1'b0, 24'h123456, 32'hcafef00d, 1'b1);
    serve(2, 1'b0, 0, 0, 1'b0);

    // Sequence wrap from all-ones.
    force dut.r_seq = 32'hffffffff;
    tick();
    release dut.r_seq;
    tick();
    m_seq = 32'hffffffff;
    check("seq_forced", seq, 32'hffffffff);
    issue(1'b1, 24'h55aa00, 32'h0, 1'b1);
    serve(1, 1'b0, 0, 0, 1'b0);
    check("seq_wrapped", seq, 32'd0);
    check("byte_queue_drained", exp_bytes.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
